instruction_fetch: RTL and testbench

Instruction fetch initiator for the pipelined processor. It drives the memory block's read port, the address / data_in / write / access_size / data_out interface, as the requesting side. It walks the program counter through the instruction address space and hands word-sized instructions to decode with a valid/stall handshake. It also accepts branch redirects from later stages and raises a sticky fault on misaligned or out-of-window fetch addresses.

---
 rtl/instruction_fetch_if.sv | 31 +++
 rtl/instruction_fetch.sv | 121 ++++++++++++
 tb/tb_instruction_fetch.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: memory read port plus decode/control handshake of the fetch unit
interface instruction_fetch_if;
    logic        start;
    logic        halt;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] mem_address;
    logic        mem_write;
    logic [1:0]  mem_access_size;
    logic [31:0] mem_data_in;
    logic [31:0] insn_out;
    logic [31:0] pc_out;
    logic        insn_valid;
    logic        busy;
    logic        fault;
    logic [31:0] fault_pc;
    logic [15:0] fetch_count;

    modport master (
        input  start, halt, stall, redirect, redirect_pc, mem_data_in,
        output mem_address, mem_write, mem_access_size, insn_out, pc_out,
               insn_valid, busy, fault, fault_pc, fetch_count
    );

    modport slave (
        output start, halt, stall, redirect, redirect_pc, mem_data_in,
        input  mem_address, mem_write, mem_access_size, insn_out, pc_out,
               insn_valid, busy, fault, fault_pc, fetch_count
    );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: walks the PC through instruction memory and hands words to decode
module instruction_fetch #(
    parameter logic [31:0] MEM_BASE  = 32'h80020000,
    parameter logic [31:0] MEM_BYTES = 32'h00100000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    instruction_fetch_if.master        bus
);
    typedef enum logic [1:0] {IDLE, FETCH, FAULT} state_t;

    localparam logic [31:0] LAST_PC = MEM_BASE + MEM_BYTES - 32'd4;

    state_t      state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic [31:0] insn_q, insn_n;
    logic [31:0] pc_q, pc_n;
    logic [31:0] fault_pc_q, fault_pc_n;
    logic        valid_q, valid_n;
    logic        fault_q, fault_n;
    logic [15:0] count_q, count_n;
    logic        legal;

    // a wrapped PC lands below MEM_BASE, so the window compare also catches it
    assign legal = (fetch_pc[1:0] == 2'b00) && (fetch_pc >= MEM_BASE) && (fetch_pc <= LAST_PC);

    assign bus.mem_address     = fetch_pc;
    assign bus.mem_write       = 1'b0;
    assign bus.mem_access_size = 2'b10;
    assign bus.insn_out        = insn_q;
    assign bus.pc_out          = pc_q;
    assign bus.insn_valid      = valid_q;
    assign bus.busy            = (state == FETCH);
    assign bus.fault           = fault_q;
    assign bus.fault_pc        = fault_pc_q;
    assign bus.fetch_count     = count_q;

    // next state and register updates; halt > redirect > stall > normal fetch
    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        insn_n     = insn_q;
        pc_n       = pc_q;
        valid_n    = valid_q;
        fault_n    = fault_q;
        fault_pc_n = fault_pc_q;
        count_n    = count_q;
        case (state)
            IDLE: begin
                valid_n = 1'b0;
                if (bus.start) begin
                    state_n    = FETCH;
                    fetch_pc_n = MEM_BASE;
                    count_n    = '0;
                    fault_n    = 1'b0;
                end
            end
            FETCH: begin
                if (bus.halt) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                end else if (bus.redirect) begin
                    fetch_pc_n = bus.redirect_pc;
                    valid_n    = 1'b0;
                end else if (!bus.stall) begin
                    if (legal) begin
                        insn_n     = bus.mem_data_in;
                        pc_n       = fetch_pc;
                        valid_n    = 1'b1;
                        fetch_pc_n = fetch_pc + 32'd4;
                        count_n    = count_q + {15'd0, count_q != 16'hFFFF};
                    end else begin
                        state_n    = FAULT;
                        fault_n    = 1'b1;
                        fault_pc_n = fetch_pc;
                        valid_n    = 1'b0;
                    end
                end
            end
            FAULT: begin
                valid_n = 1'b0;
                if (bus.halt) begin
                    state_n = IDLE;
                end else if (bus.start) begin
                    state_n    = FETCH;
                    fetch_pc_n = MEM_BASE;
                    count_n    = '0;
                    fault_n    = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // fetch datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc   <= MEM_BASE;
            insn_q     <= '0;
            pc_q       <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc   <= fetch_pc_n;
            insn_q     <= insn_n;
            pc_q       <= pc_n;
            valid_q    <= valid_n;
            fault_q    <= fault_n;
            fault_pc_q <= fault_pc_n;
            count_q    <= count_n;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed and random checks of instruction_fetch against a behavioural model
module tb_instruction_fetch;
    localparam logic [31:0] BASE  = 32'h80020000;
    localparam logic [31:0] BYTES = 32'h00100000;
    localparam logic [31:0] LAST  = BASE + BYTES - 32'd4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    instruction_fetch_if bus();

    instruction_fetch #(.MEM_BASE(BASE), .MEM_BYTES(BYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // memory contents: three preloaded words, a scrambled pattern elsewhere
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == BASE)         return 32'h11111111;
        if (a == BASE + 32'd4) return 32'h22222222;
        if (a == BASE + 32'd8) return 32'h33333333;
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    assign bus.mem_data_in = mem_word(bus.mem_address);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: mode 0 idle, 1 fetching, 2 faulted
    int          m_mode;
    logic [31:0] m_pc, m_insn, m_pco, m_fpc;
    logic        m_v, m_f;
    int          m_cnt;

    function automatic bit in_window(input logic [31:0] a);
        return (a % 4 == 0) && (a >= BASE) &&
               ({32'd0, a} + 64'd4 <= {32'd0, BASE} + {32'd0, BYTES});
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_pc = BASE; m_insn = 0; m_pco = 0;
            m_v = 0; m_f = 0; m_fpc = 0; m_cnt = 0;
        end else if (m_mode == 1) begin
            if (bus.halt) begin
                m_mode = 0; m_v = 0;
            end else if (bus.redirect) begin
                m_pc = bus.redirect_pc; m_v = 0;
            end else if (!bus.stall) begin
                if (in_window(m_pc)) begin
                    m_insn = mem_word(m_pc); m_pco = m_pc; m_v = 1;
                    m_pc = m_pc + 32'd4; m_cnt++;
                end else begin
                    m_mode = 2; m_f = 1; m_fpc = m_pc; m_v = 0;
                end
            end
        end else begin
            m_v = 0;
            if (m_mode == 2 && bus.halt) m_mode = 0;
            else if (bus.start) begin
                m_mode = 1; m_pc = BASE; m_cnt = 0; m_f = 0;
            end
        end
    end

    // every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        chk("mem_address", bus.mem_address, m_pc);
        chk("insn_out", bus.insn_out, m_insn);
        chk("pc_out", bus.pc_out, m_pco);
        chk("insn_valid", 32'(bus.insn_valid), 32'(m_v));
        chk("busy", 32'(bus.busy), 32'(m_mode == 1));
        chk("fault", 32'(bus.fault), 32'(m_f));
        chk("fault_pc", bus.fault_pc, m_fpc);
        chk("fetch_count", 32'(bus.fetch_count), (m_cnt > 65535) ? 32'hFFFF : 32'(m_cnt));
        chk("mem_write", 32'(bus.mem_write), 32'd0);
        chk("mem_access_size", 32'(bus.mem_access_size), 32'd2);
    end

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 5))
            0: return BASE + 32'($urandom_range(0, 1023)) * 32'd4;
            1: return BASE + 32'($urandom_range(0, 4095));
            2: return LAST - 32'($urandom_range(0, 3)) * 32'd4;
            3: return BASE - 32'($urandom_range(1, 4)) * 32'd4;
            4: return 32'hFFFFFFFC;
            default: return 32'($urandom());
        endcase
    endfunction

    initial begin
        bus.start = 0; bus.halt = 0; bus.stall = 0; bus.redirect = 0; bus.redirect_pc = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.insn_valid), 32'd0);
        chk("rst_addr", bus.mem_address, 32'h80020000);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_count", 32'(bus.fetch_count), 32'd0);
        rst_n = 1;
        @(negedge clk); bus.start = 1;
        @(negedge clk); bus.start = 0;
        chk("start_addr", bus.mem_address, 32'h80020000);
        chk("start_valid", 32'(bus.insn_valid), 32'd0);
        @(negedge clk);
        chk("first_pc", bus.pc_out, 32'h80020000);
        chk("first_insn", bus.insn_out, 32'h11111111);
        chk("first_valid", 32'(bus.insn_valid), 32'd1);
        @(negedge clk);
        chk("second_insn", bus.insn_out, 32'h22222222);
        bus.stall = 1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_insn", bus.insn_out, 32'h22222222);
            chk("stall_pc", bus.pc_out, 32'h80020004);
            chk("stall_addr", bus.mem_address, 32'h80020008);
            chk("stall_count", 32'(bus.fetch_count), 32'd2);
        end
        bus.stall = 0;
        @(negedge clk);
        chk("third_pc", bus.pc_out, 32'h80020008);
        chk("third_insn", bus.insn_out, 32'h33333333);
        chk("third_count", 32'(bus.fetch_count), 32'd3);
        bus.redirect = 1; bus.redirect_pc = 32'h80020100; bus.stall = 1;
        @(negedge clk); bus.redirect = 0; bus.stall = 0;
        chk("redir_valid", 32'(bus.insn_valid), 32'd0);
        chk("redir_addr", bus.mem_address, 32'h80020100);
        @(negedge clk);
        chk("redir_pc", bus.pc_out, 32'h80020100);
        chk("redir_valid2", 32'(bus.insn_valid), 32'd1);
        bus.redirect = 1; bus.redirect_pc = 32'h80020102;
        @(negedge clk); bus.redirect = 0;
        @(negedge clk);
        chk("mis_fault", 32'(bus.fault), 32'd1);
        chk("mis_fault_pc", bus.fault_pc, 32'h80020102);
        chk("mis_busy", 32'(bus.busy), 32'd0);
        bus.start = 1;
        @(negedge clk); bus.start = 0;
        chk("restart_fault", 32'(bus.fault), 32'd0);
        @(negedge clk);
        chk("restart_pc", bus.pc_out, 32'h80020000);
        bus.redirect = 1; bus.redirect_pc = 32'h8011FFFC;
        @(negedge clk); bus.redirect = 0;
        @(negedge clk);
        chk("end_pc", bus.pc_out, 32'h8011FFFC);
        chk("end_valid", 32'(bus.insn_valid), 32'd1);
        @(negedge clk);
        chk("end_fault", 32'(bus.fault), 32'd1);
        chk("end_fault_pc", bus.fault_pc, 32'h80120000);
        chk("end_valid2", 32'(bus.insn_valid), 32'd0);
        bus.start = 1;
        @(negedge clk); bus.start = 0;
        @(negedge clk);
        bus.halt = 1; bus.redirect = 1; bus.redirect_pc = 32'h12345678;
        @(negedge clk); bus.halt = 0; bus.redirect = 0;
        chk("halt_busy", 32'(bus.busy), 32'd0);
        chk("halt_addr", bus.mem_address, 32'h80020004);
        bus.start = 1;
        @(negedge clk); bus.start = 0;
        @(negedge clk);
        @(posedge clk); #2 rst_n = 0; #1;
        chk("arst_valid", 32'(bus.insn_valid), 32'd0);
        chk("arst_addr", bus.mem_address, 32'h80020000);
        chk("arst_insn", bus.insn_out, 32'd0);
        chk("arst_pc", bus.pc_out, 32'd0);
        chk("arst_count", 32'(bus.fetch_count), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk); rst_n = 1; bus.start = 1;
        @(negedge clk); bus.start = 0;
        @(negedge clk);
        chk("post_rst_pc", bus.pc_out, 32'h80020000);
        chk("post_rst_insn", bus.insn_out, 32'h11111111);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.start       = ($urandom_range(0, 9) == 0);
            bus.halt        = ($urandom_range(0, 49) == 0);
            bus.stall       = ($urandom_range(0, 3) == 0);
            bus.redirect    = ($urandom_range(0, 19) == 0);
            bus.redirect_pc = pick_target();
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 0;
                #2 rst_n = 1;
            end
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
